// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and the controller it feeds.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_TIMEOUT  = 2'b01;
    localparam logic [1:0] FC_MISALIGN = 2'b10;

    // RV32I major opcodes, shared with the controller decode.
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating up-counter with clear/enable; o_expire flags the increment that reaches LIMIT.
module fetch_wait_timer
    import fetch_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  LIMIT = '1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count == LIMIT);
    assign o_expire   = i_en && !i_clear && (r_count == LIMIT - WIDTH'(1));
    assign o_count    = r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_en && !w_at_limit) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/valid handshake, held instruction and fault detection.
// Optional FETCH_PERF_EN adds retired-instruction and memory-wait cycle counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      MAX_WAIT = 15
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_imem_valid,
    output logic [31:0]     o_instr,
    output logic            o_instr_valid,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_funct3,
    output logic            o_funct7,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    input  logic            i_exec_ack,
    input  logic            i_stall,
    input  logic            i_pc_src,
    input  logic [XLEN-1:0] i_pc_target,
    output logic            o_fault,
    output logic [1:0]      o_fault_cause,
    output logic [31:0]     o_instret_cnt,
    output logic [31:0]     o_wait_cycle_cnt
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_imem_req;
    logic            r_instr_valid;
    logic            r_fault;
    logic [1:0]      r_fault_cause;

    logic [XLEN-1:0] w_pc_plus4;
    logic            w_wait_cycle;
    logic            w_accept;
    logic            w_misalign;
    logic            w_timeout;
    logic [7:0]      w_unused_wait_count;

    assign w_pc_plus4   = r_pc + XLEN'(4);
    assign w_wait_cycle = (r_state == S_WAIT) && !i_imem_valid;
    assign w_accept     = (r_state == S_ISSUE) && i_exec_ack && !i_stall;
    assign w_misalign   = i_pc_src && !is_word_aligned(i_pc_target[1:0]);

    fetch_wait_timer #(
        .WIDTH (8),
        .LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  ((r_state != S_WAIT) || i_imem_valid),
        .i_en     (w_wait_cycle),
        .o_count  (w_unused_wait_count),
        .o_expire (w_timeout)
    );

    // imem_req and instr_valid are registered decodes of the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_RESET;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= FC_NONE;
        end else begin
            r_imem_req <= 1'b0;
            unique case (r_state)
                S_RESET: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
                S_REQ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_imem_valid) begin
                        r_instr       <= i_imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_ISSUE;
                    end else if (w_timeout) begin
                        r_fault       <= 1'b1;
                        r_fault_cause <= FC_TIMEOUT;
                        r_state       <= S_HALT;
                    end
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        r_instr_valid <= 1'b0;
                        if (w_misalign) begin
                            r_fault       <= 1'b1;
                            r_fault_cause <= FC_MISALIGN;
                            r_state       <= S_HALT;
                        end else begin
                            r_pc       <= i_pc_src ? i_pc_target : w_pc_plus4;
                            r_imem_req <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_opcode      = r_instr[6:0];
    assign o_funct3      = r_instr[14:12];
    assign o_funct7      = r_instr[30];
    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_fault       = r_fault;
    assign o_fault_cause = r_fault_cause;

`ifdef FETCH_PERF_EN
    logic w_unused_instret_sat;
    logic w_unused_wait_sat;

    fetch_wait_timer #(
        .WIDTH (32),
        .LIMIT ('1)
    ) u_instret_cnt (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (1'b0),
        .i_en     (w_accept),
        .o_count  (o_instret_cnt),
        .o_expire (w_unused_instret_sat)
    );

    fetch_wait_timer #(
        .WIDTH (32),
        .LIMIT ('1)
    ) u_wait_cycle_cnt (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (1'b0),
        .i_en     (w_wait_cycle),
        .o_count  (o_wait_cycle_cnt),
        .o_expire (w_unused_wait_sat)
    );
`else
    assign o_instret_cnt    = '0;
    assign o_wait_cycle_cnt = '0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle controller/datapath.
- Owns the PC and issues requests to instruction memory over a req/valid handshake, then latches the returned word.
- Presents opcode/funct3/funct7 to the controller and holds them until the datapath acknowledges execution.
- Consumes PCSrc and the branch/jump target to select the next PC; detects memory timeout and misaligned targets.

Parameters:
XLEN, 32, PC and instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, max cycles in WAIT before timeout fault (1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  one-cycle request pulse to instruction memory
imem_addr  output  XLEN  request address (= pc)
imem_rdata  input  32  returned instruction word
imem_valid  input  1  imem_rdata valid this cycle
instr  output  32  latched instruction
instr_valid  output  1  instr/fields valid for controller
opcode  output  7  instr[6:0]
funct3  output  3  instr[14:12]
funct7  output  1  instr[30]
pc  output  XLEN  PC of the held instruction
pc_plus4  output  XLEN  pc + 4, mod 2^XLEN
exec_ack  input  1  datapath has completed the held instruction
stall  input  1  freeze the fetch stage
PCSrc  input  1  1 = take pc_target, 0 = pc_plus4
pc_target  input  XLEN  branch/jump target
fault  output  1  sticky: timeout or misaligned target
fault_cause  output  2  00 none, 01 timeout, 10 misaligned target

Behaviour:
- Reset (synchronous, one clk edge with reset=1):
  - pc=RESET_PC; state=S_RESET.
  - instr=32'h0000_0013 (NOP).
  - imem_req=0, instr_valid=0, fault=0, fault_cause=00, wait counter=0.
  - Reset asserted in any state, including mid-WAIT, aborts the transaction. A late imem_valid after reset is ignored unless the state is S_WAIT.
- S_RESET: -> S_REQ unconditionally on the next cycle.
- S_REQ:
  - imem_req=1 and imem_addr=pc for exactly this cycle; -> S_WAIT.
  - imem_valid in S_REQ is ignored, so the minimum memory latency is 1 cycle.
- S_WAIT:
  - If imem_valid=1: instr<=imem_rdata, counter<=0, -> S_ISSUE.
  - Otherwise the counter increments. When the counter reaches MAX_WAIT with no valid: fault=1, fault_cause=01, -> S_HALT.
  - stall does not affect S_WAIT.
- S_ISSUE:
  - instr_valid=1; opcode/funct3/funct7 are decoded combinationally from the instr register.
  - If stall=1: hold everything and ignore exec_ack.
  - If exec_ack=1 and stall=0:
    - If PCSrc=1 and pc_target[1:0]!=00: fault=1, fault_cause=10, pc unchanged, -> S_HALT.
    - Otherwise pc<=PCSrc ? pc_target : pc_plus4, -> S_REQ.
- S_HALT:
  - All handshake outputs are 0 and instr_valid=0; fault is held.
  - Exit only via reset.
- Fetch-to-issue latency is 2 + (memory latency − 1) cycles. Back-to-back throughput is 1 instruction per 3 cycles at 1-cycle memory.
- pc_plus4 wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no fault.
- instr_valid is a registered state decode, so it is glitch-free.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds 32-bit outputs instret_cnt and wait_cycle_cnt.
  - instret_cnt increments on each accepted exec_ack (S_ISSUE, stall=0).
  - wait_cycle_cnt increments on each S_WAIT cycle with imem_valid=0.
  - Both clear on reset and saturate at 32'hFFFF_FFFF.
- Undefined: the ports still exist but are tied to 0, and no counter flops are generated.

Decomposition:
- Shared package fetch_pkg:
  - State enum: S_RESET, S_REQ, S_WAIT, S_ISSUE, S_HALT.
  - NOP_INSTR = 32'h0000_0013.
  - fault_cause encodings.
  - RV32I opcode constants, shared with the controller.
- One natural sub-module: fetch_wait_timer.
  - Contains the MAX_WAIT counter with clear/enable inputs and an expire output.
  - Also reused for the saturating perf counters.

Test Plan:
- Reset, memory returns 32'h00500093 one cycle after req → imem_addr=0, opcode=7'h13, funct3=0, instr_valid on 3rd cycle after reset release.
- exec_ack with PCSrc=0 at pc=0x10 → next imem_addr=0x14. With PCSrc=1, pc_target=0x40 → next imem_addr=0x40.
- stall=1 held 5 cycles in S_ISSUE while exec_ack=1 → pc, instr, instr_valid unchanged; advance occurs on the first cycle with stall=0.
- imem_valid withheld for MAX_WAIT=15 cycles → fault=1, fault_cause=01, no further imem_req until reset.
- PCSrc=1, pc_target=0x22 → fault_cause=10, pc stays at old value; a reset asserted mid-S_WAIT returns pc to RESET_PC and clears fault.
- pc=0xFFFFFFFC, PCSrc=0 → next imem_addr=0x0. With FETCH_PERF_EN, 3 retired instructions with 2-cycle memory → instret_cnt=3, wait_cycle_cnt=3.
